mem_bridge: RTL and testbench
=============================

# mem_bridge

Parametrised data-memory bridge between the compute core's single-cycle memory port and a variable-latency valid/ready memory bus. It sits in the top-level core wrapper where the data-memory port previously connected straight through. It posts stores into a write buffer, applies store byte-enable masking, and serialises loads behind buffered stores. It drives a core stall whenever a request cannot complete in the current cycle.

## Interface
- XLEN, 32: data/address width; 32 or 64.
- WBUF_DEPTH, 4: write-buffer entries; power of two, ≥2.

- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemEn  input  1  core memory request valid.
- MemWriteEn  input  1  request is a store (load when 0).
- MemAdr  input  XLEN  byte address.
- MemWriteData  input  XLEN  store data, lane-aligned.
- MemWriteByteEn  input  XLEN/8  store byte strobes.
- MemReadData  output  XLEN  load result, valid in the cycle a load completes.
- Stall  output  1  core must hold its request stable while high.
- req_valid  output  1  bus request valid.
- req_ready  input  1  bus accepts request.
- req_write  output  1  bus request is a write.
- req_addr  output  XLEN  word-aligned address: low log2(XLEN/8) bits forced to 0.
- req_wdata  output  XLEN  write data.
- req_strb  output  XLEN/8  write strobes; all-zero for reads.
- resp_valid  input  1  read data return, one cycle.
- resp_rdata  input  XLEN  read data.
- StallCount  output  32  present only with MEM_BRIDGE_PERF_EN.

## Operation
- Request handshake: the bridge accepts a core request at the rising edge ending a cycle with MemEn=1 and Stall=0. MemEn=0 gives Stall=0.
- Store path:
  - Effective strobe = MemWriteByteEn & {XLEN/8{MemWriteEn}}.
  - If count<WBUF_DEPTH: Stall=0 and the entry (address, data, strobe) is pushed.
  - If count==WBUF_DEPTH: Stall=1, even if the head pops this cycle.
  - A store with an all-zero effective strobe is accepted and discarded; it is never enqueued.
- Write buffer: circular FIFO with head/tail pointers and a count.
  - The head drives req_valid/req_write=1 whenever the FSM is not in LREQ or LWAIT.
  - Pop on req_valid&req_ready.
  - Push and pop in the same cycle leave count unchanged.
- Load FSM, with states IDLE, DRAIN, LREQ, LWAIT and LDONE:
  - IDLE: load pending, buffer empty -> LREQ; load pending, buffer non-empty -> DRAIN.
  - DRAIN: buffer empty -> LREQ.
  - LREQ: req_valid=1, req_write=0, req_strb=0. On req_ready -> LWAIT.
  - LWAIT: on resp_valid, capture resp_rdata into the load register -> LDONE.
  - LDONE: Stall=0 and MemReadData = load register. Core accepts the load -> IDLE.
- Stall for a load is 1 in every state except LDONE.
- MemReadData holds its last captured value outside LDONE.
- resp_valid outside LWAIT is ignored.
- Loads are ordered after all earlier stores. There is no store-to-load forwarding.

## Timing
- Reset values: Stall=0, MemReadData=0, req_valid=0, req_write=0, req_addr=0, req_wdata=0, req_strb=0, StallCount=0. Buffer is empty and FSM=IDLE.
- Reset mid-transaction: buffered stores are lost. An in-flight read response arriving after reset is ignored.
- Bus outputs are registered or derived only from state, never combinationally from core inputs.
- Store, buffer empty, req_ready=1:
  - Accepted in cycle 0 with zero stall.
  - req_valid high in cycle 1; popped at the end of cycle 1.
- Load, buffer empty, req_ready=1, response one cycle after the handshake:
  - Stall high in cycles 0-2; LREQ in cycle 1, LWAIT in cycle 2.
  - Data is returned in cycle 3, with Stall=0.
  - Minimum load latency: 3 stall cycles.
- Each buffered store ahead of a load adds at least 1 stall cycle (DRAIN).
- Bus request fields stay stable while req_valid=1 and req_ready=0.

## Configuration
- MEM_BRIDGE_PERF_EN defined:
  - Adds the StallCount output.
  - StallCount increments on every cycle with Stall=1 and saturates at 0xFFFF_FFFF.
  - Reset clears it.
- MEM_BRIDGE_PERF_EN undefined: the port and counter logic are absent. All other behaviour is identical.

## Test plan
- Single store, addr 0x104, data 0xDEADBEEF, strobe 0xF, req_ready=1 -> Stall=0. Next cycle req_valid=1, req_write=1, req_addr=0x104, req_strb=0xF.
- Four stores (WBUF_DEPTH=4) with req_ready=0, then a fifth store -> Stall=1 on the fifth. Raise req_ready for 1 cycle -> fifth store accepted the following cycle.
- Store with MemWriteByteEn=0xF and MemWriteEn=0 while MemEn=1 -> treated as a load. Then a store with strobe 0 -> accepted, no bus write issued.
- Two buffered stores, then a load of 0x200 with resp_rdata=0x12345678 -> reads issue only after both write handshakes. MemReadData=0x12345678 in the LDONE cycle with Stall=0.
- Drop reset low while in LWAIT, release it, then pulse resp_valid -> outputs at reset values, FSM IDLE, response ignored. With MEM_BRIDGE_PERF_EN, StallCount=0.
- XLEN=64, store addr 0x10F, strobe 0x80 -> req_addr=0x108, req_strb=0x80.

Source files
------------

// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - data-memory bridge: core memory port to valid/ready memory bus
//
// Posts core stores into a circular write buffer. Loads are serialised behind
// every buffered store, so a load never overtakes an earlier store. Stall tells
// the core to hold its request stable.
//
// Optional feature: define MEM_BRIDGE_PERF_EN to add the StallCount output.
//
// Parameters:
//   XLEN        data/address width, 32 or 64
//   WBUF_DEPTH  write-buffer entries, power of two, >= 2
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   MemEn, MemWriteEn     core request valid, store (1) or load (0)
//   MemAdr                core byte address
//   MemWriteData          store data, lane-aligned
//   MemWriteByteEn        store byte strobes
//   MemReadData           load result, valid in the cycle a load completes
//   Stall                 core must hold its request while high
//   req_valid/req_ready   bus request handshake
//   req_write             bus request is a write
//   req_addr              word-aligned bus address
//   req_wdata, req_strb   write data and strobes (strobes zero for reads)
//   resp_valid/resp_rdata single-cycle read data return
//   StallCount            saturating count of stalled cycles (MEM_BRIDGE_PERF_EN only)
module mem_bridge #(
  parameter int XLEN       = 32,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemEn,
  input  logic              MemWriteEn,
  input  logic [XLEN-1:0]   MemAdr,
  input  logic [XLEN-1:0]   MemWriteData,
  input  logic [XLEN/8-1:0] MemWriteByteEn,
  output logic [XLEN-1:0]   MemReadData,
  output logic              Stall,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [XLEN-1:0]   req_addr,
  output logic [XLEN-1:0]   req_wdata,
  output logic [XLEN/8-1:0] req_strb,
  input  logic              resp_valid,
  input  logic [XLEN-1:0]   resp_rdata
`ifdef MEM_BRIDGE_PERF_EN
  ,
  output logic [31:0]       StallCount
`endif
);

  localparam int NB = XLEN / 8;
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    LREQ,
    LWAIT,
    LDONE
  } state_t;

  state_t state, state_nx;

  logic [XLEN-1:0] wb_addr [WBUF_DEPTH];
  logic [XLEN-1:0] wb_data [WBUF_DEPTH];
  logic [NB-1:0]   wb_strb [WBUF_DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] ld_addr;
  logic [XLEN-1:0] ld_data;

  logic            store_req, load_req;
  logic [NB-1:0]   eff_strb;
  logic [XLEN-1:0] adr_aligned;
  logic            wb_full, wb_empty;
  logic            wr_phase;
  logic            push, pop;

  assign store_req   = MemEn & MemWriteEn;
  assign load_req    = MemEn & ~MemWriteEn;
  assign eff_strb    = MemWriteByteEn & {NB{MemWriteEn}};
  assign adr_aligned = MemAdr & ~XLEN'(NB - 1);
  assign wb_full     = (count == CW'(WBUF_DEPTH));
  assign wb_empty    = (count == '0);

  // The buffer head owns the bus except while the load itself is on it.
  assign wr_phase = (state != LREQ) && (state != LWAIT);

  // A full buffer stalls a store even when the head pops this cycle: the stall
  // then never depends on the bus ready.
  // A zero-strobe store is accepted without entering the buffer.
  assign push = store_req & ~wb_full & (|eff_strb);
  assign pop  = wr_phase & ~wb_empty & req_ready;

  assign Stall = (store_req & wb_full) | (load_req & (state != LDONE));

  assign MemReadData = ld_data;

  // Bus fields come only from registered state, never from the core inputs.
  always_comb begin
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    if (state == LREQ) begin
      req_valid = 1'b1;
      req_addr  = ld_addr;
    end else if (wr_phase && !wb_empty) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = wb_addr[head];
      req_wdata = wb_data[head];
      req_strb  = wb_strb[head];
    end
  end

  // Entry contents need no reset: they are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[tail] <= adr_aligned;
      wb_data[tail] <= MemWriteData;
      wb_strb[tail] <= eff_strb;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ld_addr <= '0;
      ld_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && load_req) ld_addr <= adr_aligned;
      if (state == LWAIT && resp_valid) ld_data <= resp_rdata;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load_req) state_nx = wb_empty ? LREQ : DRAIN;
      DRAIN:   if (wb_empty) state_nx = LREQ;
      LREQ:    if (req_ready) state_nx = LWAIT;
      LWAIT:   if (resp_valid) state_nx = LDONE;
      LDONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef MEM_BRIDGE_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCount <= '0;
    end else if (Stall && (StallCount != 32'hFFFF_FFFF)) begin
      StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - scoreboard bench for mem_bridge
module tb_mem_bridge;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        MemEn, MemWriteEn;
  logic [31:0] MemAdr, MemWriteData, MemReadData;
  logic [3:0]  MemWriteByteEn;
  logic        Stall;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  logic        w_MemEn, w_MemWriteEn, w_Stall;
  logic [63:0] w_MemAdr, w_MemWriteData, w_MemReadData;
  logic [7:0]  w_MemWriteByteEn;
  logic        w_req_valid, w_req_ready, w_req_write, w_resp_valid;
  logic [63:0] w_req_addr, w_req_wdata, w_resp_rdata;
  logic [7:0]  w_req_strb;
`ifdef MEM_BRIDGE_PERF_EN
  logic [31:0] stall_count, w_stall_count;
  int          tb_stalls = 0;
`endif

  mem_bridge #(.XLEN(32), .WBUF_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .MemEn(MemEn), .MemWriteEn(MemWriteEn),
    .MemAdr(MemAdr), .MemWriteData(MemWriteData), .MemWriteByteEn(MemWriteByteEn),
    .MemReadData(MemReadData), .Stall(Stall), .req_valid(req_valid),
    .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata)
`ifdef MEM_BRIDGE_PERF_EN
    , .StallCount(stall_count)
`endif
  );

  mem_bridge #(.XLEN(64), .WBUF_DEPTH(2)) dut64 (
    .clk(clk), .reset(reset), .MemEn(w_MemEn), .MemWriteEn(w_MemWriteEn),
    .MemAdr(w_MemAdr), .MemWriteData(w_MemWriteData), .MemWriteByteEn(w_MemWriteByteEn),
    .MemReadData(w_MemReadData), .Stall(w_Stall), .req_valid(w_req_valid),
    .req_ready(w_req_ready), .req_write(w_req_write), .req_addr(w_req_addr),
    .req_wdata(w_req_wdata), .req_strb(w_req_strb), .resp_valid(w_resp_valid),
    .resp_rdata(w_resp_rdata)
`ifdef MEM_BRIDGE_PERF_EN
    , .StallCount(w_stall_count)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd_addr[$];
  logic [31:0] exp_load[$];

  // Core-side view (stores applied at issue) and bus-side memory (writes applied
  // at bus handshake); a load overtaking a store makes the two disagree.
  logic [7:0]  mem_core [0:1023];
  logic [7:0]  mem_bus  [0:1023];

  int n_cmp = 0;
  int n_fail = 0;

  logic        ready_random = 1'b0;
  logic        ready_force  = 1'b1;
  logic        block_rsp    = 1'b0;
  logic        awaiting     = 1'b0;
  int          rsp_delay    = 1;
  int          rsp_cnt      = 0;
  logic [31:0] rsp_data     = '0;

  logic        prev_hold = 1'b0;
  logic [63:0] prev_ad;
  logic [4:0]  prev_ws;
  wr_t         mon_e;
  logic [31:0] mon_w;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdw(input bit bus, input logic [31:0] a);
    int b;
    b = int'(a[9:0]);
    if (bus) return {mem_bus[b+3], mem_bus[b+2], mem_bus[b+1], mem_bus[b]};
    return {mem_core[b+3], mem_core[b+2], mem_core[b+1], mem_core[b]};
  endfunction

  always @(posedge clk) begin
    #1;
    req_ready = ready_random ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Read responder: answers a read handshake after rsp_delay cycles (random
  // 1..3 when rsp_delay is 0) and injects stray pulses while no read is open.
  always @(posedge clk) begin
    #1;
    if (!block_rsp) begin
      resp_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          resp_valid = 1'b1;
          resp_rdata = rsp_data;
          awaiting   = 1'b0;
        end
      end else if (!awaiting && $urandom_range(0, 7) == 0) begin
        resp_valid = 1'b1;
        resp_rdata = $urandom;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 1'b0;
`ifdef MEM_BRIDGE_PERF_EN
      tb_stalls = 0;
`endif
    end else begin
`ifdef MEM_BRIDGE_PERF_EN
      if (Stall) tb_stalls++;
`endif
      if (prev_hold) begin
        chk("hold_valid", {63'd0, req_valid}, 64'd1);
        chk("hold_addr_data", {req_addr, req_wdata}, prev_ad);
        chk("hold_write_strb", {59'd0, req_write, req_strb}, {59'd0, prev_ws});
      end
      prev_hold = req_valid && !req_ready;
      prev_ad   = {req_addr, req_wdata};
      prev_ws   = {req_write, req_strb};
      if (req_valid && req_ready) begin
        if (req_write) begin
          if (exp_wr.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_write: addr %0h strb %0h with no store pending", req_addr, req_strb);
          end else begin
            mon_e = exp_wr.pop_front();
            chk("wr_addr", req_addr, mon_e.addr);
            chk("wr_data", req_wdata, mon_e.data);
            chk("wr_strb", req_strb, mon_e.strb);
            for (int b = 0; b < 4; b++)
              if (req_strb[b]) mem_bus[int'(req_addr[9:0]) + b] = req_wdata[8*b +: 8];
          end
        end else begin
          chk("rd_after_stores", exp_wr.size(), 0);
          chk("rd_strb", req_strb, 0);
          if (exp_rd_addr.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_read: addr %0h with no load pending", req_addr);
          end else begin
            mon_w = exp_rd_addr.pop_front();
            chk("rd_addr", req_addr, mon_w);
          end
          rsp_data = rdw(1'b1, req_addr);
          rsp_cnt  = (rsp_delay == 0) ? int'($urandom_range(1, 3)) : rsp_delay;
          awaiting = 1'b1;
        end
      end
      if (MemEn && !MemWriteEn && !Stall) begin
        if (exp_load.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_load_done: data %0h", MemReadData);
        end else begin
          mon_w = exp_load.pop_front();
          chk("load_data", MemReadData, mon_w);
        end
      end
    end
  end

  task automatic exp_store(input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] a;
    a = adr & ~32'h3;
    if (be != 0) begin
      exp_wr.push_back('{a, wd, be});
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_core[int'(a[9:0]) + b] = wd[8*b +: 8];
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        input logic [3:0] be, output int stalls);
    logic acc;
    if (we) begin
      exp_store(adr, wd, be);
    end else begin
      exp_rd_addr.push_back(adr & ~32'h3);
      exp_load.push_back(rdw(1'b0, adr & ~32'h3));
    end
    MemEn = 1'b1; MemWriteEn = we; MemAdr = adr; MemWriteData = wd; MemWriteByteEn = be;
    stalls = 0;
    acc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!Stall) begin
        acc = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL req_timeout: request at %0h never accepted", adr);
    end
    @(posedge clk); #1;
    MemEn = 1'b0; MemWriteEn = 1'b0;
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (exp_wr.size() == 0 && exp_rd_addr.size() == 0 && !awaiting) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d writes %0d reads outstanding", exp_wr.size(), exp_rd_addr.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic set_ready(input logic rnd, input logic val);
    ready_random = rnd;
    ready_force  = val;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  int st;

  initial begin
    reset = 1'b0;
    MemEn = 0; MemWriteEn = 0; MemAdr = 0; MemWriteData = 0; MemWriteByteEn = 0;
    resp_valid = 0; resp_rdata = 0; req_ready = 1;
    w_MemEn = 0; w_MemWriteEn = 0; w_MemAdr = 0; w_MemWriteData = 0; w_MemWriteByteEn = 0;
    w_req_ready = 1; w_resp_valid = 0; w_resp_rdata = 0;
    for (int i = 0; i < 1024; i++) begin
      mem_core[i] = 8'($urandom);
      mem_bus[i]  = mem_core[i];
    end
    {mem_core[515], mem_core[514], mem_core[513], mem_core[512]} = 32'h12345678;
    {mem_bus[515], mem_bus[514], mem_bus[513], mem_bus[512]}     = 32'h12345678;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", Stall, 0);
    chk("rst_rdata", MemReadData, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_write", req_write, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_wdata", req_wdata, 0);
    chk("rst_req_strb", req_strb, 0);
`ifdef MEM_BRIDGE_PERF_EN
    chk("rst_stall_count", stall_count, 0);
`endif
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // Single posted store.
    do_req(1'b1, 32'h104, 32'hDEADBEEF, 4'hF, st);
    chk("store_no_stall", st, 0);
    @(negedge clk);
    chk("store_req_valid", req_valid, 1);
    chk("store_req_write", req_write, 1);
    chk("store_req_addr", req_addr, 32'h104);
    chk("store_req_strb", req_strb, 4'hF);
    @(posedge clk); #1;
    wait_drain();

    // Fill the buffer with the bus blocked; the fifth store must wait.
    set_ready(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 32'($urandom_range(0, 255)) * 4, $urandom, 4'hF, st);
      chk("fill_no_stall", st, 0);
    end
    exp_store(32'h3C0, 32'hA5A5_0F0F, 4'h3);
    MemEn = 1; MemWriteEn = 1; MemAdr = 32'h3C0; MemWriteData = 32'hA5A5_0F0F; MemWriteByteEn = 4'h3;
    @(negedge clk);
    chk("full_stall", Stall, 1);
    ready_force = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_stall_during_pop", Stall, 1);
    ready_force = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("fifth_accepted", Stall, 0);
    @(posedge clk); #1;
    MemEn = 0; MemWriteEn = 0;
    set_ready(1'b0, 1'b1);
    wait_drain();

    // MemWriteEn=0 with strobes set is a load; a zero-strobe store writes nothing.
    rsp_delay = 1;
    do_req(1'b0, 32'h088, 32'hFFFF_FFFF, 4'hF, st);
    do_req(1'b1, 32'h040, 32'h1111_2222, 4'h0, st);
    chk("zero_strb_no_stall", st, 0);
    @(negedge clk);
    chk("zero_strb_no_write", req_valid, 0);
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end

    // Two buffered stores ahead of a load of 0x200.
    set_ready(1'b1, 1'b1);
    rsp_delay = 0;
    do_req(1'b1, 32'h010, $urandom, 4'hF, st);
    do_req(1'b1, 32'h024, $urandom, 4'h6, st);
    do_req(1'b0, 32'h200, 32'h0, 4'h0, st);
    @(negedge clk);
    chk("load_0x200_hold", MemReadData, 32'h12345678);
    @(posedge clk); #1;
    wait_drain();

    // Minimum load latency.
    set_ready(1'b0, 1'b1);
    rsp_delay = 1;
    do_req(1'b0, 32'h2F0, 32'h0, 4'h0, st);
    chk("load_latency", st, 3);

    // Reset while the load waits for its response.
    block_rsp = 1'b1;
    resp_valid = 1'b0;
    exp_rd_addr.push_back(32'h300);
    MemEn = 1; MemWriteEn = 0; MemAdr = 32'h300;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (awaiting) break;
    end
    chk("lwait_reached", awaiting, 1);
    reset = 1'b0; MemEn = 0; rsp_cnt = 0; awaiting = 1'b0;
    @(negedge clk);
    chk("midrst_stall", Stall, 0);
    chk("midrst_req_valid", req_valid, 0);
    chk("midrst_rdata", MemReadData, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 resp_valid = 1'b1; resp_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1 resp_valid = 1'b0;
    @(negedge clk);
    chk("stray_resp_ignored", MemReadData, 0);
    chk("postrst_req_valid", req_valid, 0);
    chk("postrst_stall", Stall, 0);
`ifdef MEM_BRIDGE_PERF_EN
    chk("postrst_stall_count", stall_count, 0);
`endif
    @(posedge clk); #1;
    block_rsp = 1'b0;
    do_req(1'b0, 32'h300, 32'h0, 4'h0, st);
    chk("postrst_load_latency", st, 3);

    // 64-bit instance: address alignment and strobe pass-through.
    w_MemEn = 1; w_MemWriteEn = 1; w_MemAdr = 64'h10F;
    w_MemWriteData = 64'h0123_4567_89AB_CDEF; w_MemWriteByteEn = 8'h80;
    @(negedge clk);
    chk("x64_no_stall", w_Stall, 0);
    @(posedge clk); #1 w_MemEn = 0; w_MemWriteEn = 0;
    @(negedge clk);
    chk("x64_req_valid", w_req_valid, 1);
    chk("x64_req_addr", w_req_addr, 64'h108);
    chk("x64_req_strb", w_req_strb, 8'h80);
    chk("x64_req_wdata", w_req_wdata, 64'h0123_4567_89AB_CDEF);
    @(posedge clk); #1;

    // Random mix of loads and stores.
    set_ready(1'b1, 1'b1);
    rsp_delay = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 6)
        do_req(1'b1, 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3)),
               $urandom, 4'($urandom_range(0, 15)), st);
      else
        do_req(1'b0, 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3)),
               $urandom, 4'($urandom_range(0, 15)), st);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_drain();
    chk("loads_all_done", exp_load.size(), 0);
`ifdef MEM_BRIDGE_PERF_EN
    @(negedge clk);
    chk("stall_count", stall_count, tb_stalls);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
